regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 130 +++++++++++++
 tb/tb_regfile_writeback.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Purpose: arbitrates ALU and load results into a register-file write port via a small FIFO, with bypass lookup.
// Latency: accepted at edge N, written (writeEn high) between edges N+1 and N+2; one write per cycle.
// Backpressure: mem_ready = !full, alu_ready = !full && !mem_valid (load has priority); no pass-through when full.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic [4:0]  wAddr,
  output logic [31:0] wData,
  output logic        writeEn,
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic        full,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  // Queue storage is never reset; validity comes from the pointers and count.
  wb_entry_t q_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  wb_entry_t     in_entry;
  wb_entry_t     head_entry;
  logic          mem_acc, alu_acc, push, pop;
  logic [PW-1:0] fwd_idx;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign wAddr   = waddr_q;
  assign wData   = wdata_q;
  assign writeEn = we_q;

  // Select the accepted source, drop r0 writes, and compute next queue/output state.
  always_comb begin
    mem_acc    = mem_valid && mem_ready;
    alu_acc    = alu_valid && alu_ready;
    in_entry   = mem_acc ? {mem_addr, mem_data} : {alu_addr, alu_data};
    push       = (mem_acc || alu_acc) && (in_entry.addr != 5'd0);
    pop        = !empty;
    head_entry = q_mem[rd_ptr_q];

    // Power-of-two depth: natural pointer overflow is the modulo-DEPTH wrap.
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    we_d    = pop;
    waddr_d = pop ? head_entry.addr : waddr_q;
    wdata_d = pop ? head_entry.data : wdata_q;
  end

  // Pointer, count and output-stage registers; reset discards all pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Queue storage write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr_q] <= in_entry;
    end
  end

  // Bypass lookup: output stage is oldest, then queue head..tail; the last match wins (youngest).
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    if (fwd_addr != 5'd0) begin
      if (we_q && (waddr_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (q_mem[fwd_idx].addr == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = q_mem[fwd_idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Purpose: randomized and directed bench for regfile_writeback with a queue-based reference model and scoreboard.
// Latency: expected write edge = max(accept edge + 1, previous write edge + 1).
// Backpressure: ready and full/empty predicted from the model's pending-entry count.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [4:0]  wAddr;
  logic [31:0] wData;
  logic        writeEn;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        full, empty;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wAddr(wAddr), .wData(wData), .writeEn(writeEn),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .full(full), .empty(empty)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          acc;  // edge at which the offer was accepted
    int          pop;  // edge at which it leaves the queue (writeEn high after it)
  } exp_t;

  exp_t exp_q[$];     // scoreboard of expected register writes
  exp_t fwd_list[$];  // every entry still in flight, acceptance order
  exp_t mon_ent;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int last_pop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: every writeEn must match the oldest expected write at exactly its predicted edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (writeEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_write: got writeEn=1 wAddr=%0d, expected no write (edge %0d)", wAddr, edge_n);
        end else begin
          mon_ent = exp_q.pop_front();
          check("wAddr", 32'(wAddr), 32'(mon_ent.addr));
          check("wData", wData, mon_ent.data);
          check("write_edge", edge_n, mon_ent.pop);
        end
      end else if (exp_q.size() > 0 && exp_q[0].pop <= edge_n) begin
        checks++;
        errors++;
        $display("FAIL missing_write: got writeEn=%b, expected write r%0d=%0h (edge %0d)",
                 writeEn, exp_q[0].addr, exp_q[0].data, edge_n);
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus: check state after the last edge, then drive offers for the next edge.
  task automatic step(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [4:0] fa);
    int          e;
    int          pending;
    bit          hit;
    logic [31:0] fd;
    bit          mr, ar, acc;
    exp_t        ent;
    @(negedge clk);
    e = edge_n;
    while (fwd_list.size() > 0 && fwd_list[0].pop < e) void'(fwd_list.pop_front());
    hit = 1'b0;
    fd = '0;
    pending = 0;
    foreach (fwd_list[i]) begin
      if (fwd_list[i].acc <= e && fwd_list[i].pop > e) pending++;
      if (fa != 5'd0 && fwd_list[i].acc <= e && fwd_list[i].pop >= e && fwd_list[i].addr == fa) begin
        hit = 1'b1;
        fd  = fwd_list[i].data;
      end
    end
    fwd_addr = fa;
    #1;
    check("fwd_hit", 32'(fwd_hit), 32'(hit));
    check("fwd_data", fwd_data, fd);
    check("full", 32'(full), 32'(pending == DEPTH));
    check("empty", 32'(empty), 32'(pending == 0));
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
    mr = (pending != DEPTH);
    ar = mr && !mv;
    check("mem_ready", 32'(mem_ready), 32'(mr));
    check("alu_ready", 32'(alu_ready), 32'(ar));
    acc = 1'b0;
    if (mv && mr) begin
      acc = 1'b1; ent.addr = ma; ent.data = md;
    end else if (av && ar) begin
      acc = 1'b1; ent.addr = aa; ent.data = ad;
    end
    if (acc && ent.addr != 5'd0) begin
      ent.acc = e + 1;
      ent.pop = (e + 2 > last_pop + 1) ? e + 2 : last_pop + 1;
      last_pop = ent.pop;
      exp_q.push_back(ent);
      fwd_list.push_back(ent);
    end
  endtask

  task automatic idle(input int n, input logic [4:0] fa);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fa);
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear immediately.
  task automatic reset_pulse(input logic [4:0] fa);
    @(negedge clk);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    fwd_addr  = fa;
    #2 rst_n = 1'b0;
    #1;
    check("rst_writeEn", 32'(writeEn), 32'd0);
    check("rst_wAddr", 32'(wAddr), 32'd0);
    check("rst_wData", wData, 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    exp_q.delete();
    fwd_list.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    fwd_addr = 5'd3;
    #1;
    check("init_writeEn", 32'(writeEn), 32'd0);
    check("init_wAddr", 32'(wAddr), 32'd0);
    check("init_wData", wData, 32'd0);
    check("init_empty", 32'(empty), 32'd1);
    check("init_full", 32'(full), 32'd0);
    check("init_fwd_hit", 32'(fwd_hit), 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Single ALU write to r3.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3);
    idle(4, 5'd3);

    // Simultaneous offers: load r5 first, ALU r6 waits one cycle.
    step(1'b1, 5'd5, 32'd1, 1'b1, 5'd6, 32'd2, 5'd5);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'd2, 5'd6);
    idle(3, 5'd6);

    // r0 write is swallowed; r0 lookup never hits.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd7, 5'd0);
    idle(4, 5'd0);

    // Youngest match wins: r4=10 then r4=20.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd10, 5'd4);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd20, 5'd4);
    idle(3, 5'd4);

    // Back-to-back ALU offers every cycle: the single pop per cycle keeps up.
    for (int i = 0; i < 20; i++)
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + (i % 31)), $urandom, 5'(1 + ((i + 31) % 31)));
    idle(2, 5'd0);

    // Mid-stream reset with writes in flight.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h900, 5'd9);
    step(1'b1, 5'd10, 32'hA00, 1'b0, 5'd0, 32'd0, 5'd9);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB00, 5'd10);
    reset_pulse(5'd11);
    idle(5, 5'd11);

    // Randomized traffic over a small register range to exercise r0 and address collisions.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    end
    idle(5, 5'd0);

    check("drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
